// File: rtl/riscv_boot_ctrl_if.sv
// Programmer-to-memory bus of the boot controller: UART programmer write port on one
// side, imem/dmem write port on the other.
interface riscv_boot_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              upg_wen_i;
    logic [ADDR_W-1:0] upg_adr_i;
    logic [31:0]       upg_dat_i;
    logic              upg_done_i;
    logic              upg_rst_o;
    logic              imem_wen_o;
    logic              dmem_wen_o;
    logic [ADDR_W-2:0] mem_adr_o;
    logic [31:0]       mem_dat_o;

    modport master (
        output upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        input  upg_rst_o, imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o
    );

    modport slave (
        input  upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
        output upg_rst_o, imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o
    );
endinterface

// File: rtl/riscv_boot_ctrl.sv
// Boot sequencer: switches the core between RUN and UART programming, holds it in reset
// while programming and routes programmer writes to imem or dmem by one address bit.
module riscv_boot_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int SEL_BIT     = 14,
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 2**24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_pg,
    riscv_boot_ctrl_if.slave  bus,
    output logic              cpu_rst_o,
    output logic [15:0]       word_cnt_o,
    output logic [1:0]        mode_o,
    output logic              err_o
);
    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_PROG = 2'b01,
        MODE_HOLD = 2'b10
    } mode_e;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT);

    mode_e             state_q;
    logic [HW-1:0]     hold_cnt_q;
    logic [IW-1:0]     idle_cnt_q;
    logic              start_prev_q;
    logic              cpu_rst_q;
    logic              upg_rst_q;
    logic              imem_wen_q;
    logic              dmem_wen_q;
    logic [ADDR_W-2:0] mem_adr_q;
    logic [31:0]       mem_dat_q;
    logic [15:0]       word_cnt_q;
    logic              err_q;

    logic              wr_d;
    logic [ADDR_W-2:0] mem_adr_d;
    logic [15:0]       word_cnt_d;

    // Squeeze SEL_BIT out of the programmer address: bits below it stay, bits above shift down.
    function automatic logic [ADDR_W-2:0] dropSel(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] merged;
        mask   = (ADDR_W'(1) << SEL_BIT) - ADDR_W'(1);
        merged = (a & mask) | ((a >> 1) & ~mask);
        return merged[ADDR_W-2:0];
    endfunction

    always_comb begin
        wr_d       = (state_q == MODE_PROG) && bus.upg_wen_i;
        mem_adr_d  = dropSel(bus.upg_adr_i);
        word_cnt_d = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MODE_HOLD;
            hold_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            start_prev_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            upg_rst_q    <= 1'b1;
            imem_wen_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            mem_adr_q    <= '0;
            mem_dat_q    <= '0;
            word_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            start_prev_q <= start_pg;
            imem_wen_q   <= wr_d && !bus.upg_adr_i[SEL_BIT];
            dmem_wen_q   <= wr_d && bus.upg_adr_i[SEL_BIT];
            if (wr_d) begin
                mem_adr_q  <= mem_adr_d;
                mem_dat_q  <= bus.upg_dat_i;
                word_cnt_q <= word_cnt_d;
            end

            case (state_q)
                MODE_HOLD: begin
                    if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                        state_q    <= MODE_RUN;
                        hold_cnt_q <= '0;
                        cpu_rst_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                MODE_RUN: begin
                    if (start_pg && !start_prev_q) begin
                        state_q    <= MODE_PROG;
                        cpu_rst_q  <= 1'b1;
                        upg_rst_q  <= 1'b0;
                        word_cnt_q <= '0;
                        err_q      <= 1'b0;
                        idle_cnt_q <= '0;
                    end
                end
                MODE_PROG: begin
                    if (wr_d) begin
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IW'(1);
                    end
                    // Done is checked first so a simultaneous timeout never raises err.
                    if (bus.upg_done_i) begin
                        state_q    <= MODE_HOLD;
                        hold_cnt_q <= '0;
                        upg_rst_q  <= 1'b1;
                    end else if (!wr_d && idle_cnt_q == IW'(TIMEOUT - 1)) begin
                        state_q    <= MODE_HOLD;
                        hold_cnt_q <= '0;
                        upg_rst_q  <= 1'b1;
                        err_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= MODE_HOLD;
                    hold_cnt_q <= '0;
                    cpu_rst_q  <= 1'b1;
                    upg_rst_q  <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_rst_o      = cpu_rst_q;
    assign word_cnt_o     = word_cnt_q;
    assign mode_o         = state_q;
    assign err_o          = err_q;
    assign bus.upg_rst_o  = upg_rst_q;
    assign bus.imem_wen_o = imem_wen_q;
    assign bus.dmem_wen_o = dmem_wen_q;
    assign bus.mem_adr_o  = mem_adr_q;
    assign bus.mem_dat_o  = mem_dat_q;
endmodule
